// File: rtl/acq_run_sequencer_pkg.sv
// Shared definitions for the acquisition run sequencer: FSM encoding and
// the bit layout of the two packer configuration words.
package acq_run_sequencer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RESET = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam int CR1_LEN_LSB    = 0;
  localparam int CR1_WIDTH_LSB  = 13;
  localparam int CR1_ADC_SEL    = 20;
  localparam int CR1_AUTO_ADC   = 21;
  localparam int CR1_HALF_SHIFT = 22;
  localparam int CR1_OFFSET_LSB = 23;
  localparam int CR2_SWITCH_LSB = 0;

  function automatic logic [31:0] packCfg1(
    input logic [12:0] frameLen,
    input logic [6:0]  pulseWidth,
    input logic        adcSel,
    input logic        autoAdc,
    input logic        halfShift,
    input logic [8:0]  pulseOffset
  );
    logic [31:0] w;
    w = '0;
    w[CR1_LEN_LSB +: 13]    = frameLen;
    w[CR1_WIDTH_LSB +: 7]   = pulseWidth;
    w[CR1_ADC_SEL]          = adcSel;
    w[CR1_AUTO_ADC]         = autoAdc;
    w[CR1_HALF_SHIFT]       = halfShift;
    w[CR1_OFFSET_LSB +: 9]  = pulseOffset;
    return w;
  endfunction

  // Upper byte is reserved and always reads zero.
  function automatic logic [31:0] packCfg2(input logic [23:0] switchCount);
    logic [31:0] w;
    w = '0;
    w[CR2_SWITCH_LSB +: 24] = switchCount;
    return w;
  endfunction

endpackage

// File: rtl/acq_run_sequencer_cycle_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module acq_cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            cnt <= '0;
    else if (load)       cnt <= loadVal;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/acq_run_sequencer.sv
// Run-level controller for the dual-ADC packer: shadows the host settings,
// sequences reset/settle/acquire, counts frames and handles abort/overflow.
module acq_run_sequencer
  import acq_run_sequencer_pkg::*;
#(
  parameter int RST_CYCLES  = 16,
  parameter int ARM_CYCLES  = 8,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_start,
  input  logic                   cmd_abort,
  input  logic [FRAME_CNT_W-1:0] cmd_frames,
  input  logic [12:0]            cfg_frame_len,
  input  logic [6:0]             cfg_pulse_width,
  input  logic [8:0]             cfg_pulse_offset,
  input  logic                   cfg_adc_sel,
  input  logic                   cfg_auto_adc,
  input  logic                   cfg_half_shift,
  input  logic [23:0]            cfg_switch_count,
  input  logic                   word_strobe,
  input  logic                   fifo_full,
  output logic [31:0]            config_reg_1,
  output logic [31:0]            config_reg_2,
  output logic                   packer_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [FRAME_CNT_W-1:0] frames_done
);

  localparam int TW = 16;
  localparam logic [TW-1:0] RST_LOAD = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] ARM_LOAD = TW'(ARM_CYCLES - 1);

  logic [2:0]             state, stateNext;
  logic [13:0]            wordCnt;
  logic [FRAME_CNT_W-1:0] cmdFramesQ, framesInc;
  logic                   tLoad, tExpired, startAcc, cntStrobe, frameEnd;
  logic [TW-1:0]          tVal;

  acq_cycle_timer #(.W(TW)) uTimer (
    .clk     (clk),
    .rst     (rst),
    .load    (tLoad),
    .loadVal (tVal),
    .expired (tExpired)
  );

  assign frameEnd  = (wordCnt == {1'b0, config_reg_1[CR1_LEN_LSB +: 13]});
  assign framesInc = (&frames_done) ? frames_done : frames_done + 1'b1;

  always_comb begin
    stateNext = state;
    tLoad     = 1'b0;
    tVal      = RST_LOAD;
    startAcc  = 1'b0;
    cntStrobe = 1'b0;
    case (state)
      ST_IDLE: if (cmd_start) begin
        startAcc  = 1'b1;
        tLoad     = 1'b1;
        stateNext = ST_RESET;
      end
      ST_RESET:
        if (cmd_abort) stateNext = ST_FLUSH;
        else if (tExpired) begin
          tLoad     = 1'b1;
          tVal      = ARM_LOAD;
          stateNext = ST_ARM;
        end
      ST_ARM:
        if (cmd_abort)     stateNext = ST_FLUSH;
        else if (tExpired) stateNext = ST_RUN;
      // fifo_full outranks abort, which outranks a same-cycle strobe
      ST_RUN:
        if (fifo_full || cmd_abort) stateNext = ST_FLUSH;
        else if (word_strobe) begin
          cntStrobe = 1'b1;
          if (frameEnd && cmdFramesQ != '0 && framesInc == cmdFramesQ)
            stateNext = ST_DONE;
        end
      ST_FLUSH: if (!fifo_full) stateNext = ST_DONE;
      ST_DONE:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      wordCnt      <= '0;
      cmdFramesQ   <= '0;
      frames_done  <= '0;
      overflow     <= 1'b0;
      config_reg_1 <= '0;
      config_reg_2 <= '0;
      packer_rst   <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state      <= stateNext;
      packer_rst <= !(state == ST_ARM || state == ST_RUN);
      busy       <= (state != ST_IDLE);
      done       <= (state == ST_DONE);
      if (startAcc) begin
        config_reg_1 <= packCfg1(cfg_frame_len, cfg_pulse_width, cfg_adc_sel,
                                 cfg_auto_adc, cfg_half_shift, cfg_pulse_offset);
        config_reg_2 <= packCfg2(cfg_switch_count);
        cmdFramesQ   <= cmd_frames;
        wordCnt      <= '0;
        frames_done  <= '0;
        overflow     <= 1'b0;
      end else if (cntStrobe) begin
        if (frameEnd) begin
          wordCnt     <= '0;
          frames_done <= framesInc;
        end else begin
          wordCnt <= wordCnt + 1'b1;
        end
      end
      if (state == ST_RUN && fifo_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_acq_run_sequencer.sv
// Scenario bench for acq_run_sequencer with a queue of expected frame counts.
module tb_acq_run_sequencer;

  localparam int FW = 4;
  localparam logic [FW-1:0] FMAX = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_start = 1'b0, cmd_abort = 1'b0;
  logic [FW-1:0] cmd_frames = '0;
  logic [12:0]   cfg_frame_len = '0;
  logic [6:0]    cfg_pulse_width = '0;
  logic [8:0]    cfg_pulse_offset = '0;
  logic          cfg_adc_sel = 1'b0, cfg_auto_adc = 1'b0, cfg_half_shift = 1'b0;
  logic [23:0]   cfg_switch_count = '0;
  logic          word_strobe = 1'b0, fifo_full = 1'b0;
  logic [31:0]   config_reg_1, config_reg_2;
  logic          packer_rst, busy, done, overflow;
  logic [FW-1:0] frames_done;

  int            nChecks = 0, nFail = 0;
  logic [FW-1:0] expQ[$];
  logic [FW-1:0] expF;
  int            mWords;
  logic [FW-1:0] mFrames;
  logic [12:0]   mLen;

  acq_run_sequencer #(.RST_CYCLES(16), .ARM_CYCLES(8), .FRAME_CNT_W(FW)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cmd_frames(cmd_frames), .cfg_frame_len(cfg_frame_len),
    .cfg_pulse_width(cfg_pulse_width), .cfg_pulse_offset(cfg_pulse_offset),
    .cfg_adc_sel(cfg_adc_sel), .cfg_auto_adc(cfg_auto_adc),
    .cfg_half_shift(cfg_half_shift), .cfg_switch_count(cfg_switch_count),
    .word_strobe(word_strobe), .fifo_full(fifo_full),
    .config_reg_1(config_reg_1), .config_reg_2(config_reg_2),
    .packer_rst(packer_rst), .busy(busy), .done(done), .overflow(overflow),
    .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start is sampled at the next edge; returns just after that edge.
  task automatic doStart(input logic [FW-1:0] frames, input logic [12:0] len);
    cfg_frame_len = len;
    cmd_frames    = frames;
    cmd_start     = 1'b1;
    tick();
    cmd_start = 1'b0;
    mWords  = 0;
    mFrames = '0;
    mLen    = len;
  endtask

  // Model of one counted strobe; pushes the frame count it should produce.
  task automatic pushStrobe();
    if (mWords == int'(mLen)) begin
      mWords = 0;
      if (mFrames != FMAX) mFrames = mFrames + 1'b1;
    end else begin
      mWords++;
    end
    expQ.push_back(mFrames);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    nChecks++; if (packer_rst !== 1'b1) begin nFail++; $display("FAIL reset_packer_rst got=%b want=1", packer_rst); end
    nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy got=%b want=0", busy); end
    nChecks++; if (done !== 1'b0) begin nFail++; $display("FAIL reset_done got=%b want=0", done); end
    nChecks++; if (overflow !== 1'b0) begin nFail++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    nChecks++; if (frames_done !== '0) begin nFail++; $display("FAIL reset_frames got=%0d want=0", frames_done); end
    nChecks++; if (config_reg_1 !== 32'h0) begin nFail++; $display("FAIL reset_cfg1 got=%h want=0", config_reg_1); end
    nChecks++; if (config_reg_2 !== 32'h0) begin nFail++; $display("FAIL reset_cfg2 got=%h want=0", config_reg_2); end
    rst = 1'b1;
    cmd_abort = 1'b1;
    tick(); tick();
    cmd_abort = 1'b0;
    nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL idle_abort_busy got=%b want=0", busy); end
  endtask

  task automatic test_timing();
    logic e;
    doStart('0, 13'd0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      e = (k <= 16);
      nChecks++; if (packer_rst !== e) begin nFail++; $display("FAIL timing_packer_rst cyc=%0d got=%b want=%b", k, packer_rst, e); end
      if (k == 1) begin
        nChecks++; if (busy !== 1'b1) begin nFail++; $display("FAIL timing_busy got=%b want=1", busy); end
      end
    end
    for (int k = 18; k <= 24; k++) begin
      word_strobe = 1'b1;
      expQ.push_back(mFrames);
      tick();
      expF = expQ.pop_front();
      nChecks++; if (frames_done !== expF) begin nFail++; $display("FAIL timing_arm_strobe cyc=%0d got=%0d want=%0d", k, frames_done, expF); end
    end
    pushStrobe();
    tick();
    word_strobe = 1'b0;
    expF = expQ.pop_front();
    nChecks++; if (frames_done !== expF) begin nFail++; $display("FAIL timing_first_count got=%0d want=%0d", frames_done, expF); end
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    tick();
    nChecks++; if (packer_rst !== 1'b1 || done !== 1'b0) begin nFail++; $display("FAIL timing_abort_m1 got=%b%b want=10", packer_rst, done); end
    tick();
    nChecks++; if (done !== 1'b1) begin nFail++; $display("FAIL timing_abort_done got=%b want=1", done); end
    tick();
    nChecks++; if (busy !== 1'b0 || done !== 1'b0) begin nFail++; $display("FAIL timing_abort_idle got=%b%b want=00", busy, done); end
  endtask

  task automatic test_normal();
    int pulses;
    doStart(FW'(2), 13'd3);
    repeat (24) tick();
    for (int i = 0; i < 8; i++) begin
      word_strobe = 1'b1;
      pushStrobe();
      tick();
      expF = expQ.pop_front();
      nChecks++; if (frames_done !== expF) begin nFail++; $display("FAIL normal_frames strobe=%0d got=%0d want=%0d", i + 1, frames_done, expF); end
    end
    word_strobe = 1'b0;
    nChecks++; if (frames_done !== FW'(2)) begin nFail++; $display("FAIL normal_final got=%0d want=2", frames_done); end
    nChecks++; if (done !== 1'b0) begin nFail++; $display("FAIL normal_done_early got=%b want=0", done); end
    tick();
    nChecks++; if (done !== 1'b1 || packer_rst !== 1'b1) begin nFail++; $display("FAIL normal_done got=%b%b want=11", done, packer_rst); end
    tick();
    nChecks++; if (busy !== 1'b0 || packer_rst !== 1'b1) begin nFail++; $display("FAIL normal_idle got=%b%b want=01", busy, packer_rst); end
    pulses = 0;
    repeat (4) begin tick(); if (done) pulses++; end
    nChecks++; if (pulses != 0) begin nFail++; $display("FAIL normal_extra_done got=%0d want=0", pulses); end
    nChecks++; if (frames_done !== FW'(2)) begin nFail++; $display("FAIL normal_hold got=%0d want=2", frames_done); end
  endtask

  task automatic test_overflow();
    doStart('0, 13'd3);
    repeat (24) tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        nChecks++; if (overflow !== 1'b1) begin nFail++; $display("FAIL ovf_set got=%b want=1", overflow); end
      end
      if (i == 1) begin
        nChecks++; if (packer_rst !== 1'b1) begin nFail++; $display("FAIL ovf_packer_rst got=%b want=1", packer_rst); end
      end
    end
    nChecks++; if (done !== 1'b0) begin nFail++; $display("FAIL ovf_done_while_full got=%b want=0", done); end
    fifo_full = 1'b0;
    tick();
    nChecks++; if (done !== 1'b0) begin nFail++; $display("FAIL ovf_done_early got=%b want=0", done); end
    tick();
    nChecks++; if (done !== 1'b1) begin nFail++; $display("FAIL ovf_done got=%b want=1", done); end
    tick(); tick();
    nChecks++; if (busy !== 1'b0 || overflow !== 1'b1) begin nFail++; $display("FAIL ovf_sticky got=%b%b want=01", busy, overflow); end
    doStart(FW'(1), 13'd0);
    nChecks++; if (overflow !== 1'b0) begin nFail++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    repeat (24) tick();
    word_strobe = 1'b1;
    tick();
    word_strobe = 1'b0;
    tick();
    nChecks++; if (done !== 1'b1 || frames_done !== FW'(1)) begin nFail++; $display("FAIL single_frame got=%b/%0d want=1/1", done, frames_done); end
    tick();
  endtask

  task automatic test_collision();
    doStart('0, 13'd0);
    repeat (24) tick();
    word_strobe = 1'b1;
    pushStrobe();
    tick();
    expF = expQ.pop_front();
    nChecks++; if (frames_done !== expF) begin nFail++; $display("FAIL coll_pre got=%0d want=%0d", frames_done, expF); end
    cmd_abort = 1'b1;
    expQ.push_back(mFrames);
    tick();
    word_strobe = 1'b0; cmd_abort = 1'b0;
    expF = expQ.pop_front();
    nChecks++; if (frames_done !== expF || overflow !== 1'b0) begin nFail++; $display("FAIL coll_abort got=%0d/%b want=%0d/0", frames_done, overflow, expF); end
    tick();
    nChecks++; if (packer_rst !== 1'b1) begin nFail++; $display("FAIL coll_flush got=%b want=1", packer_rst); end
    tick();
    nChecks++; if (done !== 1'b1) begin nFail++; $display("FAIL coll_done got=%b want=1", done); end
    tick();
    doStart('0, 13'd0);
    repeat (24) tick();
    word_strobe = 1'b1; cmd_abort = 1'b1; fifo_full = 1'b1;
    tick();
    word_strobe = 1'b0; cmd_abort = 1'b0; fifo_full = 1'b0;
    nChecks++; if (overflow !== 1'b1 || frames_done !== '0) begin nFail++; $display("FAIL coll_all got=%b/%0d want=1/0", overflow, frames_done); end
    tick(); tick();
    nChecks++; if (done !== 1'b1) begin nFail++; $display("FAIL coll_all_done got=%b want=1", done); end
    tick();
  endtask

  task automatic test_config();
    logic [31:0] exp1, exp2;
    logic [12:0] lenField;
    bit          seen;
    cfg_pulse_width = 7'h55; cfg_pulse_offset = 9'h1A3; cfg_adc_sel = 1'b1;
    cfg_auto_adc = 1'b0; cfg_half_shift = 1'b1; cfg_switch_count = 24'hABCDEF;
    exp1 = {9'h1A3, 1'b1, 1'b0, 1'b1, 7'h55, 13'h0FF};
    exp2 = {8'h00, 24'hABCDEF};
    doStart('0, 13'h0FF);
    nChecks++; if (config_reg_1 !== exp1) begin nFail++; $display("FAIL cfg1_pack got=%h want=%h", config_reg_1, exp1); end
    nChecks++; if (config_reg_2 !== exp2) begin nFail++; $display("FAIL cfg2_pack got=%h want=%h", config_reg_2, exp2); end
    repeat (24) tick();
    cfg_frame_len = 13'h010; cfg_switch_count = 24'h0;
    tick(); tick();
    lenField = config_reg_1[12:0];
    nChecks++; if (lenField !== 13'h0FF || config_reg_2 !== exp2) begin nFail++; $display("FAIL cfg_stable got=%h/%h want=0ff/%h", lenField, config_reg_2, exp2); end
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tick(); tick();
    nChecks++; if (busy !== 1'b1 || packer_rst !== 1'b0 || config_reg_1 !== exp1) begin nFail++; $display("FAIL cfg_start_ignored got=%b%b/%h want=10/%h", busy, packer_rst, config_reg_1, exp1); end
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); if (done) seen = 1; end
    nChecks++; if (!seen) begin nFail++; $display("FAIL cfg_done_timeout got=0 want=1"); end
    tick();
    doStart('0, 13'h010);
    lenField = config_reg_1[12:0];
    nChecks++; if (lenField !== 13'h010) begin nFail++; $display("FAIL cfg_new_len got=%h want=010", lenField); end
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); if (done) seen = 1; end
    nChecks++; if (!seen) begin nFail++; $display("FAIL cfg_done2_timeout got=0 want=1"); end
    tick();
  endtask

  task automatic test_async_reset();
    bit seen;
    doStart('0, 13'd0);
    repeat (24) tick();
    word_strobe = 1'b1;
    repeat (3) tick();
    word_strobe = 1'b0;
    #2 rst = 1'b0;
    #1;
    nChecks++; if (busy !== 1'b0 || packer_rst !== 1'b1) begin nFail++; $display("FAIL areset_ctrl got=%b%b want=01", busy, packer_rst); end
    nChecks++; if (config_reg_1 !== 32'h0 || config_reg_2 !== 32'h0) begin nFail++; $display("FAIL areset_cfg got=%h/%h want=0/0", config_reg_1, config_reg_2); end
    nChecks++; if (frames_done !== '0) begin nFail++; $display("FAIL areset_frames got=%0d want=0", frames_done); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    doStart('0, 13'd0);
    repeat (24) tick();
    for (int i = 0; i < 20; i++) begin
      word_strobe = 1'b1;
      pushStrobe();
      tick();
      expF = expQ.pop_front();
      nChecks++; if (frames_done !== expF) begin nFail++; $display("FAIL cont_frames strobe=%0d got=%0d want=%0d", i + 1, frames_done, expF); end
    end
    word_strobe = 1'b0;
    tick();
    nChecks++; if (busy !== 1'b1 || done !== 1'b0) begin nFail++; $display("FAIL cont_running got=%b%b want=10", busy, done); end
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); if (done) seen = 1; end
    nChecks++; if (!seen) begin nFail++; $display("FAIL cont_done_timeout got=0 want=1"); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_normal();
    test_overflow();
    test_collision();
    test_config();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
